uart_tx_arbiter: RTL and testbench



---
 rtl/uart_pkg.sv | 32 +++
 rtl/rr_arbiter.sv | 36 +++
 rtl/uart_tx_arbiter.sv | 134 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the urt_tx front-end arbiter: FSM encoding, frame
// timing defaults and constant-evaluable sizing helpers.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_FIRE  = 2'd2,
        ST_WAIT  = 2'd3
    } state_e;

    localparam int unsigned DEF_CLKS_PER_BIT = 868;
    localparam int unsigned DEF_FRAME_BITS   = 10;
    localparam int unsigned DEF_GAP_CYCLES   = 2;

    // Bits needed to index n items; never less than one bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'(1) << r) < 64'(n)) begin
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

    function automatic int unsigned frame_cycles(input int unsigned clks_per_bit,
                                                 input int unsigned frame_bits,
                                                 input int unsigned gap_cycles);
        return clks_per_bit * frame_bits + gap_cycles;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping modulo NUM_REQ.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W  = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               any
);

    // Scan from the farthest offset down so the nearest asserted index wins.
    always_comb begin
        int                 j;
        logic [IDX_W-1:0]   jj;
        any     = 1'b0;
        gnt_idx = '0;
        j       = 0;
        jj      = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= int'(NUM_REQ)) begin
                j = j - int'(NUM_REQ);
            end
            jj = IDX_W'(j);
            if (req[jj]) begin
                any     = 1'b1;
                gnt_idx = jj;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin front end for urt_tx: captures one byte per frame slot from
// NUM_REQ producers and times each frame locally, since urt_tx has no done.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int unsigned FRAME_BITS   = DEF_FRAME_BITS,
    parameter int unsigned GAP_CYCLES   = DEF_GAP_CYCLES,
    localparam int unsigned IDX_W       = clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic                 trig,
    output logic [7:0]           data_to_send,
    output logic                 busy,
    output logic [IDX_W-1:0]     cur_id
);

    localparam int unsigned FRAME_CYCLES = frame_cycles(CLKS_PER_BIT, FRAME_BITS, GAP_CYCLES);
    localparam int unsigned CNT_W        = clog2(FRAME_CYCLES);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     cur_id_q, cur_id_d;
    logic [NUM_REQ-1:0]   req_ack_q, req_ack_d;
    logic                 trig_q, trig_d;
    logic                 busy_q, busy_d;
    logic [7:0]           data_q, data_d;

    logic [IDX_W-1:0]     arb_gnt;
    logic                 arb_any;
    logic [7:0]           req_bytes [NUM_REQ];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt_idx (arb_gnt),
        .any     (arb_any)
    );

    always_comb begin
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            req_bytes[i] = req_data[8*i +: 8];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; WAIT exits on the cycle its counter steps to zero.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (arb_any) state_d = ST_GRANT;
            ST_GRANT: state_d = ST_FIRE;
            ST_FIRE:  state_d = ST_WAIT;
            ST_WAIT:  if (cnt_q <= CNT_W'(1)) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values; the winner is latched in IDLE.
    always_comb begin
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        cur_id_d  = cur_id_q;
        data_d    = data_q;
        req_ack_d = '0;
        trig_d    = (state_d == ST_FIRE);
        busy_d    = (state_d != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    cur_id_d  = arb_gnt;
                    req_ack_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << arb_gnt;
                end
            end
            ST_GRANT: begin
                data_d = req_bytes[cur_id_q];
                ptr_d  = (cur_id_q == IDX_W'(NUM_REQ - 1)) ? '0 : cur_id_q + IDX_W'(1);
            end
            ST_FIRE: begin
                cnt_d = CNT_W'(FRAME_CYCLES - 1);
            end
            ST_WAIT: begin
                if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    // Output, pointer and frame-counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            ptr_q     <= '0;
            cur_id_q  <= '0;
            req_ack_q <= '0;
            trig_q    <= 1'b0;
            busy_q    <= 1'b0;
            data_q    <= '0;
        end else begin
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            cur_id_q  <= cur_id_d;
            req_ack_q <= req_ack_d;
            trig_q    <= trig_d;
            busy_q    <= busy_d;
            data_q    <= data_d;
        end
    end

    assign req_ack      = req_ack_q;
    assign trig         = trig_q;
    assign busy         = busy_q;
    assign data_to_send = data_q;
    assign cur_id       = cur_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter with CLKS_PER_BIT=4: per-requester byte queues
// drive the handshake, a scoreboard holds the expected (id, byte) per frame.
module tb_uart_tx_arbiter;

    localparam int FC     = 42;
    localparam int PERIOD = 44;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ack;
    logic        trig;
    logic [7:0]  data_to_send;
    logic        busy;
    logic [1:0]  cur_id;

    typedef struct {
        int         id;
        logic [7:0] data;
    } exp_t;

    exp_t       sb [$];
    logic [7:0] src_q [4][$];
    logic [3:0] pend_ack;
    int         cyc;
    int         n_checks = 0;
    int         n_fail   = 0;

    uart_tx_arbiter #(
        .NUM_REQ      (4),
        .CLKS_PER_BIT (4),
        .FRAME_BITS   (10),
        .GAP_CYCLES   (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ack      (req_ack),
        .trig         (trig),
        .data_to_send (data_to_send),
        .busy         (busy),
        .cur_id       (cur_id)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_update();
        for (int i = 0; i < 4; i++) begin
            req_valid[i]       = (src_q[i].size() > 0);
            req_data[8*i +: 8] = (src_q[i].size() > 0) ? src_q[i][0] : 8'h00;
        end
    endtask

    // Advance one clock; a requester acked last cycle moves to its next byte now.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 4; i++) begin
            if (pend_ack[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        end
        drive_update();
        pend_ack = req_ack;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) src_q[i].delete();
        sb.delete();
        pend_ack = '0;
        drive_update();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 4'hF;
        req_data  = 32'h5A5A5A5A;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (trig !== 1'b0) begin n_fail++; $display("FAIL reset_trig: got %b want 0", trig); end
        n_checks++; if (req_ack !== 4'h0) begin n_fail++; $display("FAIL reset_ack: got %b want 0000", req_ack); end
        n_checks++; if (data_to_send !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", data_to_send); end
        n_checks++; if (cur_id !== 2'd0) begin n_fail++; $display("FAIL reset_cur_id: got %0d want 0", cur_id); end
        n_checks++; if (dut.ptr_q !== 2'd0) begin n_fail++; $display("FAIL reset_ptr: got %0d want 0", dut.ptr_q); end
        do_reset();
    endtask

    task automatic test_single();
        exp_t       e;
        bit         stable;
        logic [7:0] rx;
        logic       start_b, stop_b, line;
        int         b;
        do_reset();
        src_q[0].push_back(8'hAB);
        sb.push_back('{id: 0, data: 8'hAB});
        drive_update();
        tick();
        n_checks++; if (req_ack !== 4'b0001) begin n_fail++; $display("FAIL single_ack: got %b want 0001", req_ack); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_c1: got %b want 1", busy); end
        n_checks++; if (trig !== 1'b0) begin n_fail++; $display("FAIL single_trig_c1: got %b want 0", trig); end
        tick();
        e = sb.pop_front();
        n_checks++; if (trig !== 1'b1) begin n_fail++; $display("FAIL single_trig_c2: got %b want 1", trig); end
        n_checks++; if (data_to_send !== e.data) begin n_fail++; $display("FAIL single_data_c2: got %h want %h", data_to_send, e.data); end
        stable = 1'b1; rx = '0; start_b = 1'b1; stop_b = 1'b0;
        for (int c = 3; c <= 43; c++) begin
            tick();
            if (data_to_send !== 8'hAB || busy !== 1'b1 || trig !== 1'b0 || req_ack !== 4'h0) stable = 1'b0;
            if (c < 43 && ((c - 3) % 4) == 2) begin
                b = (c - 3) / 4;
                line = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : data_to_send[3'(b - 1)];
                if (b == 0) start_b = line;
                else if (b == 9) stop_b = line;
                else rx[3'(b - 1)] = line;
            end
        end
        n_checks++; if (!stable) begin n_fail++; $display("FAIL single_frame_stable: got unstable want stable AB/busy through cycle 43"); end
        n_checks++; if (rx !== 8'hAB || start_b !== 1'b0 || stop_b !== 1'b1) begin
            n_fail++; $display("FAIL single_serial: got start=%b byte=%h stop=%b want 0/AB/1", start_b, rx, stop_b); end
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_c44: got %b want 0", busy); end
    endtask

    task automatic test_round_robin();
        exp_t e;
        int   trigs, last;
        bit   ok;
        do_reset();
        src_q[0].push_back(8'h10); src_q[0].push_back(8'h10);
        src_q[1].push_back(8'h11);
        src_q[2].push_back(8'h12);
        src_q[3].push_back(8'h13);
        sb.push_back('{id: 0, data: 8'h10});
        sb.push_back('{id: 1, data: 8'h11});
        sb.push_back('{id: 2, data: 8'h12});
        sb.push_back('{id: 3, data: 8'h13});
        sb.push_back('{id: 0, data: 8'h10});
        drive_update();
        trigs = 0; last = -1;
        for (int c = 0; c < 6 * PERIOD && trigs < 5; c++) begin
            tick();
            if (req_ack != 4'h0) begin
                n_checks++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL rr_ack: got %b want none", req_ack); end
                else if (req_ack !== 4'(1 << sb[0].id)) begin n_fail++; $display("FAIL rr_ack: got %b want id %0d", req_ack, sb[0].id); end
            end
            if (trig) begin
                n_checks++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL rr_trig: got extra trig want none"); end
                else begin
                    e = sb.pop_front();
                    if (data_to_send !== e.data) begin n_fail++; $display("FAIL rr_data: got %h want %h", data_to_send, e.data); end
                end
                if (last >= 0) begin
                    n_checks++;
                    if (cyc - last != PERIOD) begin n_fail++; $display("FAIL rr_spacing: got %0d want %0d", cyc - last, PERIOD); end
                end
                last = cyc;
                trigs++;
            end
        end
        n_checks++; if (trigs != 5) begin n_fail++; $display("FAIL rr_count: got %0d trigs want 5", trigs); end
        wait_idle(100, ok);
        n_checks++; if (!ok || src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size() != 0) begin
            n_fail++; $display("FAIL rr_drain: got idle=%b want idle with all bytes consumed", ok); end
    endtask

    task automatic test_ptr_wrap();
        exp_t e;
        int   trigs;
        bit   ok;
        do_reset();
        src_q[1].push_back(8'h01);
        drive_update();
        tick();
        wait_idle(100, ok);
        n_checks++; if (!ok || dut.ptr_q !== 2'd2) begin n_fail++; $display("FAIL wrap_ptr_setup: got %0d want 2", dut.ptr_q); end
        src_q[3].push_back(8'h33);
        src_q[1].push_back(8'h11);
        sb.push_back('{id: 3, data: 8'h33});
        sb.push_back('{id: 1, data: 8'h11});
        drive_update();
        trigs = 0;
        for (int c = 0; c < 3 * PERIOD && trigs < 2; c++) begin
            tick();
            if (req_ack != 4'h0) begin
                n_checks++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL wrap_ack: got %b want none", req_ack); end
                else if (req_ack !== 4'(1 << sb[0].id)) begin n_fail++; $display("FAIL wrap_ack: got %b want id %0d", req_ack, sb[0].id); end
            end
            if (trig) begin
                n_checks++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL wrap_trig: got extra trig want none"); end
                else begin
                    e = sb.pop_front();
                    if (data_to_send !== e.data) begin n_fail++; $display("FAIL wrap_data: got %h want %h", data_to_send, e.data); end
                end
                trigs++;
            end
        end
        n_checks++; if (trigs != 2) begin n_fail++; $display("FAIL wrap_count: got %0d trigs want 2", trigs); end
        wait_idle(100, ok);
        n_checks++; if (!ok || dut.ptr_q !== 2'd2) begin n_fail++; $display("FAIL wrap_ptr_end: got %0d want 2", dut.ptr_q); end
    endtask

    task automatic test_wait_request();
        exp_t e;
        int   tref;
        bit   bad, idle;
        do_reset();
        src_q[0].push_back(8'hC3);
        sb.push_back('{id: 0, data: 8'hC3});
        drive_update();
        tick();
        tick();
        e = sb.pop_front();
        n_checks++; if (trig !== 1'b1 || data_to_send !== e.data) begin
            n_fail++; $display("FAIL wait_first_trig: got trig=%b data=%h want 1/%h", trig, data_to_send, e.data); end
        tref = cyc;
        repeat (10) tick();
        src_q[2].push_back(8'h5C);
        sb.push_back('{id: 2, data: 8'h5C});
        drive_update();
        bad = 1'b0; idle = 1'b0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (!busy) begin idle = 1'b1; break; end
            if (req_ack !== 4'h0 || data_to_send !== 8'hC3) bad = 1'b1;
        end
        n_checks++; if (bad) begin n_fail++; $display("FAIL wait_ignored: got ack or data change during WAIT want none"); end
        n_checks++; if (!idle || cyc - tref != FC) begin n_fail++; $display("FAIL wait_idle_cycle: got %0d want %0d after trig", cyc - tref, FC); end
        tick();
        n_checks++; if (req_ack !== 4'b0100 || cur_id !== 2'd2) begin
            n_fail++; $display("FAIL wait_next_ack: got ack=%b id=%0d want 0100/2", req_ack, cur_id); end
        tick();
        e = sb.pop_front();
        n_checks++; if (trig !== 1'b1 || data_to_send !== e.data) begin
            n_fail++; $display("FAIL wait_next_trig: got trig=%b data=%h want 1/%h", trig, data_to_send, e.data); end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   trigs;
        bit   ok;
        do_reset();
        src_q[0].push_back(8'h77);
        drive_update();
        tick();
        tick();
        repeat (20) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (busy !== 1'b0 || trig !== 1'b0) begin n_fail++; $display("FAIL mid_busy_trig: got %b/%b want 0/0", busy, trig); end
        n_checks++; if (data_to_send !== 8'h00) begin n_fail++; $display("FAIL mid_data: got %h want 00", data_to_send); end
        n_checks++; if (dut.ptr_q !== 2'd0 || cur_id !== 2'd0) begin
            n_fail++; $display("FAIL mid_ptr_id: got ptr=%0d id=%0d want 0/0", dut.ptr_q, cur_id); end
        src_q[3].push_back(8'h33);
        src_q[0].push_back(8'h21);
        sb.push_back('{id: 0, data: 8'h21});
        sb.push_back('{id: 3, data: 8'h33});
        drive_update();
        trigs = 0;
        for (int c = 0; c < 3 * PERIOD && trigs < 2; c++) begin
            tick();
            if (req_ack != 4'h0) begin
                n_checks++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL mid_ack: got %b want none", req_ack); end
                else if (req_ack !== 4'(1 << sb[0].id)) begin n_fail++; $display("FAIL mid_ack: got %b want id %0d", req_ack, sb[0].id); end
            end
            if (trig) begin
                n_checks++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL mid_trig: got extra trig want none"); end
                else begin
                    e = sb.pop_front();
                    if (data_to_send !== e.data) begin n_fail++; $display("FAIL mid_data_after: got %h want %h", data_to_send, e.data); end
                end
                trigs++;
            end
        end
        n_checks++; if (trigs != 2) begin n_fail++; $display("FAIL mid_count: got %0d trigs want 2", trigs); end
        wait_idle(100, ok);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   trigs, last, extra;
        bit   ok;
        logic [7:0] v;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            v = 8'hA0 + 8'(k);
            src_q[1].push_back(v);
            sb.push_back('{id: 1, data: v});
        end
        drive_update();
        trigs = 0; last = -1;
        for (int c = 0; c < 6 * PERIOD && trigs < 5; c++) begin
            tick();
            if (req_ack != 4'h0) begin
                n_checks++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL b2b_ack: got %b want none", req_ack); end
                else if (req_ack !== 4'(1 << sb[0].id)) begin n_fail++; $display("FAIL b2b_ack: got %b want id %0d", req_ack, sb[0].id); end
            end
            if (trig) begin
                n_checks++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL b2b_trig: got extra trig want none"); end
                else begin
                    e = sb.pop_front();
                    if (data_to_send !== e.data) begin n_fail++; $display("FAIL b2b_data: got %h want %h", data_to_send, e.data); end
                end
                if (last >= 0) begin
                    n_checks++;
                    if (cyc - last != PERIOD) begin n_fail++; $display("FAIL b2b_spacing: got %0d want %0d", cyc - last, PERIOD); end
                end
                last = cyc;
                trigs++;
            end
        end
        n_checks++; if (trigs != 5) begin n_fail++; $display("FAIL b2b_count: got %0d trigs want 5", trigs); end
        wait_idle(100, ok);
        extra = 0;
        repeat (50) begin
            tick();
            if (req_ack != 4'h0 || trig) extra++;
        end
        n_checks++; if (!ok || extra != 0 || src_q[1].size() != 0) begin
            n_fail++; $display("FAIL b2b_no_extra: got %0d extra events, %0d bytes left want 0/0", extra, src_q[1].size()); end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        pend_ack  = '0;
        cyc       = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_ptr_wrap();
        test_wait_request();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
